// File: rtl/csa_if.sv
// csa_if: operand/result handshake bundle for csa_accum
interface csa_if #(parameter int WL = 13, parameter int CW = 4);
  logic start;
  logic in_valid;
  logic in_ready;
  logic [WL-1:0] a;
  logic [WL-1:0] b;
  logic cin1;
  logic cin2;
  logic [WL-1:0] Ws;
  logic [WL-1:0] Wc;
  logic [WL-1:0] W;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic [CW-1:0] count;
  modport master (
    output start, in_valid, a, b, cin1, cin2, out_ready,
    input  in_ready, Ws, Wc, W, out_valid, busy, count
  );
  modport slave (
    input  start, in_valid, a, b, cin1, cin2, out_ready,
    output in_ready, Ws, Wc, W, out_valid, busy, count
  );
endinterface

// File: rtl/csa_accum.sv
// csa_accum: redundant (carry-save) residual accumulator built on a 4:2 compressor
module csa_accum #(
  parameter int WL = 13,
  parameter int STEPS = 13,
  parameter bit SHIFT = 1'b1,
  localparam int CW = $clog2(STEPS + 1)
) (
  input logic clk,
  input logic rst,
  csa_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WL-1:0] ws, wc, xs, xc, s1, m1, t, m2, ns, nc;
  logic [CW-1:0] cnt;
  logic acc;
  // Two chained 3:2 stages: the first stage's carries form the transfer word with cin1 at bit 0
  always_comb begin
    xs = SHIFT ? {ws[WL-2:0], 1'b0} : ws;
    xc = SHIFT ? {wc[WL-2:0], 1'b0} : wc;
    s1 = xs ^ xc ^ bus.a;
    m1 = (xs & xc) | (xs & bus.a) | (xc & bus.a);
    t = {m1[WL-2:0], bus.cin1};
    ns = s1 ^ t ^ bus.b;
    m2 = (s1 & t) | (s1 & bus.b) | (t & bus.b);
    nc = {m2[WL-2:0], bus.cin2};
    acc = (state == RUN) && bus.in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ws <= '0;
      wc <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        state <= RUN;
        ws <= '0;
        wc <= '0;
        cnt <= '0;
      end
      if (acc) begin
        ws <= ns;
        wc <= nc;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(STEPS - 1)) state <= DONE;
      end
      if (state == DONE && bus.out_ready) state <= IDLE;
    end
  end
  assign bus.in_ready = state == RUN;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.Ws = ws;
  assign bus.Wc = wc;
  assign bus.W = ws + wc;
  assign bus.count = cnt;
endmodule

// File: doc/csa_accum.md
CSA_ACCUM -- requirements
Module: csa_accum

Interface
REQ-001 Parameter: WL, 13, width of the redundant residual words and operands.
REQ-002 Parameter: STEPS, 13, number of digit steps per operation (>=1).
REQ-003 Parameter: SHIFT, 1, 1 = residual doubled (shifted left one bit) before each add (radix-2 online recurrence); 0 = plain accumulate.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: start  in  1  begin a new operation (sampled only in IDLE).
REQ-007 Port: in_valid / in_ready  in / out  1 / 1  operand handshake; a step is accepted when both are high on a clock edge.
REQ-008 Port: a, b  in  WL each  operand words added per step.
REQ-009 Port: cin1, cin2  in  1 each  carry-ins per step (cin1 into the 4:2 transfer chain at bit 0, cin2 into Wc[0]).
REQ-010 Port: Ws, Wc  out  WL each  registered sum/carry residual.
REQ-011 Port: W  out  WL  (Ws + Wc) mod 2^WL, combinational carry-propagate of the registered residual.
REQ-012 Port: out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 Port: busy  out  1  high in RUN and DONE.
REQ-014 Port: count  out  clog2(STEPS+1)  number of steps accepted in the current operation.

Function
REQ-015 States IDLE, RUN, DONE; state register only, no other hidden state affects outputs.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> Ws=Wc=0, count=0, next RUN.
REQ-017 RUN: in_ready=1; on accept, residual <= 4:2 CSA of (X_s, X_c, a, b) with cin1/cin2, where X = residual<<1 (bit WL-1 discarded) if SHIFT=1, else residual; count increments.
REQ-018 Arithmetic invariant after each accept: (Ws+Wc) mod 2^WL == (k*prev + a + b + cin1 + cin2) mod 2^WL, k = 2 if SHIFT else 1; the carry out of bit WL-1 is discarded; exact Ws/Wc bit split is implementation-defined.
REQ-019 Update is single-cycle: the new residual is visible on Ws/Wc/W the cycle after acceptance; no accept cycle -> residual and count hold.
REQ-020 Accept with count==STEPS-1 -> count=STEPS, next DONE (STEPS=1: first accept goes to DONE).
REQ-021 DONE: in_ready=0, out_valid=1, Ws/Wc/W/count held stable until out_valid&&out_ready, then next IDLE; residual retained in IDLE until next start.
REQ-022 start in RUN or DONE is ignored; in_valid outside RUN is ignored; start and out_ready in the same DONE cycle -> IDLE only (start not latched).
REQ-023 in_valid toggling inside RUN is legal; count advances only on accepted cycles.

Reset
REQ-024 rst=1 at a clock edge -> state IDLE, Ws=Wc=0, W=0, count=0, in_ready=0, out_valid=0, busy=0, from any state including mid-RUN and DONE; rst overrides start.

Verification
REQ-025 Reset: assert rst 2 cycles in RUN after 5 accepts -> next cycle IDLE, Ws=Wc=W=0, count=0, busy=0.
REQ-026 WL=13, STEPS=13, SHIFT=1: start, then 13 back-to-back accepts a=1,b=0,cin1=cin2=0 -> DONE, W=0x1FFF, count=13, out_valid=1.
REQ-027 WL=13, STEPS=4, SHIFT=0: 4 accepts a=100,b=200,cin1=1,cin2=0 -> W=1204; invariant of REQ-018 checked after every accept.
REQ-028 Wrap: WL=13, STEPS=1, SHIFT=0: a=b=0x1FFF, cin1=cin2=1 -> W=0x0000 (16384 mod 8192).
REQ-029 Stall: same as REQ-027 with in_valid low on alternate cycles -> result 1204 after 8 RUN cycles, count never advances on idle cycles.
REQ-030 Backpressure: out_ready low 10 cycles in DONE with start pulsed -> Ws/Wc/W/count stable, state stays DONE; out_ready high with start high -> IDLE, busy=0 next cycle, no new operation begins.
